// File: rtl/audio_mix_pwm.sv
// Channel mixer and PWM DAC: sync/glitch-filter tone samples, volume, sum, gain+saturate, PWM.
// Optional sticky clip indicator enabled by defining AUDIO_MIX_CLIP_FLAG_EN.
module audio_mix_pwm #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*NUM_CH-1:0]   ch_sample,
    input  logic [4*NUM_CH-1:0]   ch_vol,
    input  logic [NUM_CH-1:0]     ch_en,
    input  logic [1:0]            gain,
`ifdef AUDIO_MIX_CLIP_FLAG_EN
    input  logic                  clip_clr,
    output logic                  clip_flag,
`endif
    output logic [PWM_BITS-1:0]   mix_level,
    output logic [PWM_BITS-1:0]   duty,
    output logic                  period_start,
    output logic                  pwm_out
);

    localparam int unsigned SMP_W  = 4 * NUM_CH;
    localparam int unsigned PROD_W = 8;
    localparam int unsigned SUM_W  = 8 + $clog2(NUM_CH);
    localparam int unsigned G_W    = SUM_W + 3;
    localparam int unsigned SHIFT  = SUM_W - PWM_BITS;

    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic [SMP_W-1:0]         sync1;
    logic [SMP_W-1:0]         sync2;
    logic [SMP_W-1:0]         sync3;
    logic [SMP_W-1:0]         samp_q;
    logic [NUM_CH*PROD_W-1:0] prod_q;
    logic [SUM_W-1:0]         sum_c;
    logic [SUM_W-1:0]         sum_q;
    logic [1:0]               gain_p;
    logic [1:0]               gain_s;
    logic [G_W-1:0]           g_c;
    logic [G_W-1:0]           v_c;
    logic                     sat_c;

    logic [PWM_BITS-1:0]      pwm_cnt;
    logic                     cnt_run;
    logic [PWM_BITS-1:0]      cnt_nxt_c;
    logic                     load_c;
    logic [PWM_BITS-1:0]      duty_nxt_c;

    // Three-flop synchroniser for the slow-domain sample bus
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= ch_sample;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Per-channel glitch filter: accept a nibble only once it has been seen twice in a row
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (sync2[4*i +: 4] == sync3[4*i +: 4]) begin
                    samp_q[4*i +: 4] <= sync2[4*i +: 4];
                end
            end
        end
    end

    // Stage P: volume multiply with enable; gain travels alongside to stay aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            gain_p <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (ch_en[i]) begin
                    prod_q[PROD_W*i +: PROD_W] <= PROD_W'(samp_q[4*i +: 4]) * PROD_W'(ch_vol[4*i +: 4]);
                end else begin
                    prod_q[PROD_W*i +: PROD_W] <= '0;
                end
            end
            gain_p <= gain;
        end
    end

    // Stage S: unsigned adder tree, sized so it cannot overflow
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            sum_c = sum_c + SUM_W'(prod_q[PROD_W*i +: PROD_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            gain_s <= '0;
        end else begin
            sum_q  <= sum_c;
            gain_s <= gain_p;
        end
    end

    // Stage L: master gain, rescale to PWM width, saturate
    always_comb begin
        g_c   = G_W'(sum_q) << gain_s;
        v_c   = g_c >> SHIFT;
        sat_c = (v_c > G_W'(LVL_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mix_level <= '0;
        end else if (sat_c) begin
            mix_level <= LVL_MAX;
        end else begin
            mix_level <= v_c[PWM_BITS-1:0];
        end
    end

`ifdef AUDIO_MIX_CLIP_FLAG_EN
    // Sticky clip indicator; a new saturation beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_flag <= 1'b0;
        end else if (sat_c) begin
            clip_flag <= 1'b1;
        end else if (clip_clr) begin
            clip_flag <= 1'b0;
        end
    end
`endif

    // Counter holds at 0 for the first cycle out of reset so a period starts right away
    always_comb begin
        cnt_nxt_c  = cnt_run ? (pwm_cnt + PWM_BITS'(1)) : '0;
        load_c     = cnt_run && (pwm_cnt == CNT_MAX);
        duty_nxt_c = load_c ? mix_level : duty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt      <= '0;
            cnt_run      <= 1'b0;
            duty         <= '0;
            period_start <= 1'b0;
            pwm_out      <= 1'b0;
        end else begin
            pwm_cnt      <= cnt_nxt_c;
            cnt_run      <= 1'b1;
            duty         <= duty_nxt_c;
            period_start <= (cnt_nxt_c == '0);
            pwm_out      <= (cnt_nxt_c < duty_nxt_c);
        end
    end

endmodule

// File: tb/tb_audio_mix_pwm.sv
// Directed + randomized bench for audio_mix_pwm against an arithmetic reference model.
module tb_audio_mix_pwm;

    localparam int NUM_CH   = 4;
    localparam int PWM_BITS = 8;
    localparam int PERIOD   = 256;
    localparam int LMAX     = 255;

    logic        clk;
    logic        rst;
    logic [15:0] ch_sample;
    logic [15:0] ch_vol;
    logic [3:0]  ch_en;
    logic [1:0]  gain;
    logic [7:0]  mix_level;
    logic [7:0]  duty;
    logic        period_start;
    logic        pwm_out;
`ifdef AUDIO_MIX_CLIP_FLAG_EN
    logic        clip_clr;
    logic        clip_flag;
`endif

    int vectors     = 0;
    int miscompares = 0;

    audio_mix_pwm #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_sample    (ch_sample),
        .ch_vol       (ch_vol),
        .ch_en        (ch_en),
        .gain         (gain),
`ifdef AUDIO_MIX_CLIP_FLAG_EN
        .clip_clr     (clip_clr),
        .clip_flag    (clip_flag),
`endif
        .mix_level    (mix_level),
        .duty         (duty),
        .period_start (period_start),
        .pwm_out      (pwm_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model state: sample history seen by the input stage, filtered
    // sample values, pending unclipped levels, and time since reset release.
    logic [15:0] seen_q[$];
    int          filt[NUM_CH];
    int          lvl_q[$];
    int          m_mix, m_duty, m_k;
    bit          m_ps, m_pwm, m_clip;

    function automatic int raw_level(input logic [15:0] vol, input logic [3:0] en, input logic [1:0] g);
        int sum;
        logic [15:0] vv;
        sum = 0;
        vv  = vol;
        for (int i = 0; i < NUM_CH; i++) begin
            if (en[i]) sum += filt[i] * int'(vv[4*i +: 4]);
        end
        return (sum * (2 ** int'(g))) / 4;
    endfunction

    task automatic model_reset();
        seen_q = {};
        repeat (3) seen_q.push_back(16'h0);
        lvl_q = {};
        repeat (2) lvl_q.push_back(0);
        for (int i = 0; i < NUM_CH; i++) filt[i] = 0;
        m_mix = 0; m_duty = 0; m_k = -1;
        m_ps = 0; m_pwm = 0; m_clip = 0;
    endtask

    task automatic model_edge(input bit r, input logic [15:0] s, input logic [15:0] v,
                              input logic [3:0] e, input logic [1:0] g, input bit cc);
        int nl, popped;
        logic [15:0] older, newer;
        if (r) begin
            model_reset();
        end else begin
            nl     = raw_level(v, e, g);
            popped = lvl_q.pop_front();
            lvl_q.push_back(nl);
            m_k = m_k + 1;
            if (m_k > 0 && (m_k % PERIOD) == 0) m_duty = m_mix;
            m_mix = (popped > LMAX) ? LMAX : popped;
            if (popped > LMAX) m_clip = 1;
            else if (cc)       m_clip = 0;
            older = seen_q[0];
            newer = seen_q[1];
            for (int i = 0; i < NUM_CH; i++) begin
                if (older[4*i +: 4] == newer[4*i +: 4]) filt[i] = int'(newer[4*i +: 4]);
            end
            void'(seen_q.pop_front());
            seen_q.push_back(s);
            m_ps  = ((m_k % PERIOD) == 0);
            m_pwm = ((m_k % PERIOD) < m_duty);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare
    task automatic step();
        logic [15:0] s_in, v_in;
        logic [3:0]  e_in;
        logic [1:0]  g_in;
        bit          r_in, cc_in;
        @(posedge clk);
        s_in = ch_sample; v_in = ch_vol; e_in = ch_en; g_in = gain; r_in = rst;
`ifdef AUDIO_MIX_CLIP_FLAG_EN
        cc_in = clip_clr;
`else
        cc_in = 1'b0;
`endif
        model_edge(r_in, s_in, v_in, e_in, g_in, cc_in);
        #1;
        check("mix_level",    32'(mix_level),    32'(m_mix));
        check("duty",         32'(duty),         32'(m_duty));
        check("period_start", 32'(period_start), 32'(m_ps));
        check("pwm_out",      32'(pwm_out),      32'(m_pwm));
`ifdef AUDIO_MIX_CLIP_FLAG_EN
        check("clip_flag",    32'(clip_flag),    32'(m_clip));
`endif
    endtask

    task automatic wait_period();
        int n;
        n = 0;
        step();
        while (period_start !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        check("period_start_seen", 32'(period_start), 32'd1);
    endtask

    // Count high cycles over one period starting at the current cycle (pwm_cnt == 0)
    task automatic count_period(input int chg_at, output int hi);
        hi = int'(pwm_out);
        for (int i = 1; i < PERIOD; i++) begin
            step();
            hi += int'(pwm_out);
            if (i == chg_at) ch_en = 4'hF;
        end
    endtask

    initial begin
        int hi;
        int idx;
        model_reset();
        // Reset with nonzero inputs (single-channel setup)
        rst       = 1'b1;
        ch_sample = 16'hA5CF;
        ch_vol    = 16'h739F;
        ch_en     = 4'b0001;
        gain      = 2'd0;
`ifdef AUDIO_MIX_CLIP_FLAG_EN
        clip_clr  = 1'b0;
`endif
        repeat (3) step();
        check("rst_pwm_out",      32'(pwm_out),      32'd0);
        check("rst_duty",         32'(duty),         32'd0);
        check("rst_mix_level",    32'(mix_level),    32'd0);
        check("rst_period_start", 32'(period_start), 32'd0);
        rst = 1'b0;
        step();
        check("first_period_start", 32'(period_start), 32'd1);

        // Single channel 15*15 -> 225 >> 2 = 56 at edge 7
        repeat (5) step();
        check("mix_pre_edge7", 32'(mix_level), 32'd0);
        step();
        check("mix_56_edge7", 32'(mix_level), 32'd56);
        wait_period();
        count_period(-1, hi);
        check("high_56", 32'(hi), 32'd56);

        // One-cycle glitch on ch0 must not disturb the mix
        ch_sample[3:0] = 4'h0;
        step();
        ch_sample[3:0] = 4'hF;
        repeat (10) step();
        check("glitch_mix_56", 32'(mix_level), 32'd56);

        // Mid-period change 56 -> 128 at pwm_cnt 100
        ch_sample = 16'h1FFF;
        ch_vol    = 16'h24FF;
        repeat (10) step();
        wait_period();
        count_period(97, hi);
        check("midperiod_keep_56", 32'(hi), 32'd56);
        check("mix_128", 32'(mix_level), 32'd128);
        wait_period();
        count_period(-1, hi);
        check("high_128", 32'(hi), 32'd128);

        // Saturation: 900 << 1 >> 2 = 450 -> 255
        ch_sample = 16'hFFFF;
        ch_vol    = 16'hFFFF;
        ch_en     = 4'hF;
        gain      = 2'd1;
        wait_period();
        wait_period();
        check("mix_sat_255", 32'(mix_level), 32'd255);
        count_period(-1, hi);
        check("high_255", 32'(hi), 32'd255);
`ifdef AUDIO_MIX_CLIP_FLAG_EN
        check("clip_set", 32'(clip_flag), 32'd1);
        clip_clr = 1'b1;
        repeat (3) step();
        check("clip_set_wins", 32'(clip_flag), 32'd1);
        ch_en = 4'h0;
        repeat (6) step();
        check("clip_cleared", 32'(clip_flag), 32'd0);
        clip_clr = 1'b0;
`endif

        // Mute: only ch0 active, then disable it
        ch_en = 4'b0001;
        gain  = 2'd0;
        wait_period();
        wait_period();
        check("mute_pre_mix", 32'(mix_level), 32'd56);
        ch_en = 4'b0000;
        repeat (3) step();
        check("mute_mix_0", 32'(mix_level), 32'd0);
        wait_period();
        count_period(-1, hi);
        check("mute_high_0", 32'(hi), 32'd0);

        // Reset mid-period, then duty stays 0 until the first load
        ch_en = 4'b0001;
        repeat (60) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_mid_period_start", 32'(period_start), 32'd1);
        check("rst_mid_duty0",        32'(duty),         32'd0);

        // Randomized traffic, checked cycle by cycle against the model
        for (int c = 0; c < 2500; c++) begin
            idx = int'($urandom_range(0, NUM_CH - 1));
            if ($urandom_range(0, 2) == 0) ch_sample[4*idx +: 4] = 4'($urandom);
            if ($urandom_range(0, 40) == 0) ch_vol = 16'($urandom);
            if ($urandom_range(0, 60) == 0) ch_en = 4'($urandom);
            if ($urandom_range(0, 80) == 0) gain = 2'($urandom);
            rst = ($urandom_range(0, 699) == 0);
`ifdef AUDIO_MIX_CLIP_FLAG_EN
            clip_clr = ($urandom_range(0, 9) == 0);
`endif
            step();
        end
        rst = 1'b0;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
